fft_wrapper: RTL and testbench
==============================

# fft_wrapper

8-point complex radix-2 FFT engine with an input holding buffer and a start/ready handshake. A `write` pulse captures eight complex 16-bit samples. A `start` pulse runs a three-stage decimation-in-time FFT on the buffered samples and presents eight registered complex results. It sits between a sample-capture front end and downstream spectral processing.

## Interface
- `DATA_W`, default 16: two's-complement width of every real/imag input and output word.
- `CLK` input 1: single clock; all logic on the rising edge.
- `RST_N` input 1: reset, synchronous, active-high. Asserted when 1, despite the name.
- `write` input 1: load `in0..in7` into the input buffer at this edge.
- `start` input 1: launch a transform of the buffer contents.
- `inK_real`, K=0..7, input DATA_W each: real part of time sample x[K], signed.
- `inK_imag`, K=0..7, input DATA_W each: imaginary part of x[K], signed.
- `outK_real`, K=0..7, output DATA_W each: real part of X[K], natural order, signed.
- `outK_imag`, K=0..7, output DATA_W each: imaginary part of X[K], signed.
- `ready` output 1: high while `out*` holds a completed transform.

## Operation
- FSM states: IDLE, S1, S2, S3.
  - IDLE + `start` → S1.
  - S1 → S2 → S3 unconditionally.
  - S3 → IDLE.
- Input buffer: 16 registers, updated on every edge with `write`=1, in any state.
  - `start` and `write` in the same cycle: the transform uses the buffer contents from *before* that edge. The new data is kept for the next `start`.
- Stage 1 (S1 edge): input is the bit-reversed buffer (0,4,2,6,1,5,3,7). Span-1 butterflies, twiddle W0.
- Stage 2: span-2 butterflies, twiddles W0, W2.
- Stage 3: span-4 butterflies, twiddles W0..W3. Results go to the output registers.
- Butterfly: a' = a + W·b, b' = a − W·b.
- Twiddle format: W^k = e^(−j2πk/8) in Q1.14.
  - W0=(16384,0), W1=(11585,−11585), W2=(0,−16384), W3=(−11585,−11585).
  - W0 and W2 are implemented as pass-through and negate/swap, with no multiplier.
- Complex product: each 32-bit partial product is summed in full width, then +8192 and arithmetic shift right 14 (round half up). The result is truncated to DATA_W.
- No per-stage scaling. Sums are DATA_W+1 bits internally, then reduced to DATA_W (see Configuration).
- `start` outside IDLE is ignored. An in-flight transform is never disturbed by `write`.

## Timing
- Reset (RST_N=1 at an edge): FSM=IDLE, buffer=0, all `out*`=0, `ready`=0. Reset overrides a simultaneous `write`/`start` and aborts an in-flight transform.
- `start` sampled at edge E:
  - `ready` falls after E.
  - Stages register at E+1 and E+2.
  - `out*` and `ready`=1 update at E+3.
- Latency is 3 cycles from the `start` edge to valid outputs.
- `ready` stays high, and `out*` stay stable, until the next accepted `start` or reset.
- Back-to-back: a new `start` is accepted in the first cycle the FSM is IDLE again, i.e. the cycle in which `ready` rises.

## Configuration
- `FFT_SATURATE_EN` defined: every butterfly sum/difference and every rounded product saturates to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- `FFT_SATURATE_EN` undefined: two's-complement wrap (keep the low DATA_W bits).
- Results for in-range data are identical either way.

## Structure
- Package `fft_pkg`:
  - constants N=8, DATA_W=16, TW_FRAC=14;
  - twiddle real/imag constant arrays;
  - a packed complex struct {real, imag};
  - bit-reverse index function.
- One sub-module, `fft_butterfly`:
  - ports: complex a, complex b, twiddle index;
  - outputs: complex a', b';
  - combinational, with the rounding/saturation logic inside.
- The top instantiates 4 butterflies per stage (12 total) and holds the FSM, buffer and output registers.

## Test plan
- Reset: RST_N=1 for 2 cycles → all `out*`=0, `ready`=0. `start` during reset → no transform.
- x=[50,50,50,50,0,0,0,0] real, write then start → `ready` 3 cycles after start; X0=200+0j, X2=X4=X6=0, X1=50−121j, X3=50−21j, X5=50+21j, X7=50+121j (±1 LSB).
- Write [100,200,300,400,400,300,200,100] in the same cycle as start → outputs equal the previous buffer's FFT. A second start → X0=2000, X2=X4=X6=0, X7=conj(X1), X5=conj(X3).
- start while S1/S2 → ignored; `ready` still rises exactly 3 cycles after the first start.
- RST_N=1 in S2 → outputs 0, `ready` never rises for that run.
- x0=32767, others 32767: with FFT_SATURATE_EN → X0=32767; without → X0 wraps to the low 16 bits of the ideal value 262136, i.e. −8.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, types and helpers for the 8-point FFT
// Q1.14 twiddles W0..W3, complex sample type, FSM states and bit reversal.
package fft_pkg;
    localparam int N       = 8;
    localparam int DATA_W  = 16;
    localparam int TW_FRAC = 14;
    localparam int TW_W    = 16;

    localparam logic signed [TW_W-1:0] TW_RE [4] = '{16'sd16384,  16'sd11585,  16'sd0,     -16'sd11585};
    localparam logic signed [TW_W-1:0] TW_IM [4] = '{16'sd0,     -16'sd11585, -16'sd16384, -16'sd11585};

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;

    function automatic logic [2:0] bit_rev(input logic [2:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction
endpackage

// File: rtl/fft_wrapper_if.sv
// rtl/fft_wrapper_if.sv - sample/result bundle between capture front end and FFT
// master drives samples and write/start; slave (the FFT) returns results and ready.
interface fft_wrapper_if #(parameter int DATA_W = fft_pkg::DATA_W);
    logic write;
    logic start;
    logic ready;
    logic signed [DATA_W-1:0] in0_real, in1_real, in2_real, in3_real,
                              in4_real, in5_real, in6_real, in7_real;
    logic signed [DATA_W-1:0] in0_imag, in1_imag, in2_imag, in3_imag,
                              in4_imag, in5_imag, in6_imag, in7_imag;
    logic signed [DATA_W-1:0] out0_real, out1_real, out2_real, out3_real,
                              out4_real, out5_real, out6_real, out7_real;
    logic signed [DATA_W-1:0] out0_imag, out1_imag, out2_imag, out3_imag,
                              out4_imag, out5_imag, out6_imag, out7_imag;

    modport master (
        output write, start,
        output in0_real, in1_real, in2_real, in3_real, in4_real, in5_real, in6_real, in7_real,
        output in0_imag, in1_imag, in2_imag, in3_imag, in4_imag, in5_imag, in6_imag, in7_imag,
        input  ready,
        input  out0_real, out1_real, out2_real, out3_real, out4_real, out5_real, out6_real, out7_real,
        input  out0_imag, out1_imag, out2_imag, out3_imag, out4_imag, out5_imag, out6_imag, out7_imag
    );

    modport slave (
        input  write, start,
        input  in0_real, in1_real, in2_real, in3_real, in4_real, in5_real, in6_real, in7_real,
        input  in0_imag, in1_imag, in2_imag, in3_imag, in4_imag, in5_imag, in6_imag, in7_imag,
        output ready,
        output out0_real, out1_real, out2_real, out3_real, out4_real, out5_real, out6_real, out7_real,
        output out0_imag, out1_imag, out2_imag, out3_imag, out4_imag, out5_imag, out6_imag, out7_imag
    );
endinterface

// File: rtl/fft_butterfly.sv
// rtl/fft_butterfly.sv - combinational radix-2 DIT butterfly a +/- W*b
// FFT_SATURATE_EN selects saturation of products and sums; otherwise results wrap.
module fft_butterfly
    import fft_pkg::*;
(
    input  cplx_t      a,
    input  cplx_t      b,
    input  logic [1:0] tw_idx,
    output cplx_t      a_out,
    output cplx_t      b_out
);
    localparam int PW = 2 * DATA_W + 2;
    localparam logic signed [PW-1:0] ROUND   = PW'(1 << (TW_FRAC - 1));
    localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

    function automatic logic signed [DATA_W-1:0] reduce(input logic signed [PW-1:0] v);
`ifdef FFT_SATURATE_EN
        if (v > SAT_MAX) return SAT_MAX[DATA_W-1:0];
        if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
`endif
        return DATA_W'(v);
    endfunction

    logic signed [PW-1:0] ar, ai, br, bi, wr, wi, pr, pi;
    cplx_t wb;

    always_comb begin
        ar = PW'(a.re);
        ai = PW'(a.im);
        br = PW'(b.re);
        bi = PW'(b.im);
        wr = PW'(TW_RE[tw_idx]);
        wi = PW'(TW_IM[tw_idx]);
        // W0 and W2 are exact in Q1.14, so they bypass the multiplier
        case (tw_idx)
            2'd0: begin
                pr = br;
                pi = bi;
            end
            2'd2: begin
                pr = bi;
                pi = -br;
            end
            default: begin
                pr = (br * wr - bi * wi + ROUND) >>> TW_FRAC;
                pi = (br * wi + bi * wr + ROUND) >>> TW_FRAC;
            end
        endcase
        wb.re    = reduce(pr);
        wb.im    = reduce(pi);
        a_out.re = reduce(ar + PW'(wb.re));
        a_out.im = reduce(ai + PW'(wb.im));
        b_out.re = reduce(ar - PW'(wb.re));
        b_out.im = reduce(ai - PW'(wb.im));
    end
endmodule

// File: rtl/fft_wrapper.sv
// rtl/fft_wrapper.sv - 8-point radix-2 DIT FFT with input buffer and start/ready
// Three registered stages; arithmetic mode follows FFT_SATURATE_EN in fft_butterfly.
module fft_wrapper
    import fft_pkg::*;
(
    input  logic         CLK,
    input  logic         RST_N,
    fft_wrapper_if.slave io
);
    state_t state_q, state_d;
    logic   accept, last;
    logic   ready_q;

    cplx_t in_c   [N];
    cplx_t smp_q  [N];
    cplx_t snap_q [N];
    cplx_t st1_q  [N];
    cplx_t st2_q  [N];
    cplx_t out_q  [N];
    cplx_t st1_d  [N];
    cplx_t st2_d  [N];
    cplx_t st3_d  [N];

    assign in_c[0] = '{re: io.in0_real, im: io.in0_imag};
    assign in_c[1] = '{re: io.in1_real, im: io.in1_imag};
    assign in_c[2] = '{re: io.in2_real, im: io.in2_imag};
    assign in_c[3] = '{re: io.in3_real, im: io.in3_imag};
    assign in_c[4] = '{re: io.in4_real, im: io.in4_imag};
    assign in_c[5] = '{re: io.in5_real, im: io.in5_imag};
    assign in_c[6] = '{re: io.in6_real, im: io.in6_imag};
    assign in_c[7] = '{re: io.in7_real, im: io.in7_imag};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: if (io.start) begin
                state_d = S1;
                accept  = 1'b1;
            end
            S1:      state_d = S2;
            S2:      state_d = S3;
            S3: begin
                state_d = IDLE;
                last    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // The snapshot taken on the accepting edge isolates the run from later writes
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                smp_q[k]  <= '0;
                snap_q[k] <= '0;
                st1_q[k]  <= '0;
                st2_q[k]  <= '0;
                out_q[k]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (io.write) smp_q <= in_c;
            if (accept) begin
                ready_q <= 1'b0;
                for (int k = 0; k < N; k++) snap_q[k] <= smp_q[bit_rev(3'(k))];
            end
            if (state_q == S1) st1_q <= st1_d;
            if (state_q == S2) st2_q <= st2_d;
            if (last) begin
                out_q   <= st3_d;
                ready_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_bfly
        localparam int A2 = (g / 2) * 4 + (g % 2);

        fft_butterfly u_s1 (
            .a(snap_q[2*g]), .b(snap_q[2*g+1]), .tw_idx(2'd0),
            .a_out(st1_d[2*g]), .b_out(st1_d[2*g+1])
        );
        fft_butterfly u_s2 (
            .a(st1_q[A2]), .b(st1_q[A2+2]), .tw_idx(2'((g % 2) * 2)),
            .a_out(st2_d[A2]), .b_out(st2_d[A2+2])
        );
        fft_butterfly u_s3 (
            .a(st2_q[g]), .b(st2_q[g+4]), .tw_idx(2'(g)),
            .a_out(st3_d[g]), .b_out(st3_d[g+4])
        );
    end

    assign io.ready     = ready_q;
    assign io.out0_real = out_q[0].re;
    assign io.out1_real = out_q[1].re;
    assign io.out2_real = out_q[2].re;
    assign io.out3_real = out_q[3].re;
    assign io.out4_real = out_q[4].re;
    assign io.out5_real = out_q[5].re;
    assign io.out6_real = out_q[6].re;
    assign io.out7_real = out_q[7].re;
    assign io.out0_imag = out_q[0].im;
    assign io.out1_imag = out_q[1].im;
    assign io.out2_imag = out_q[2].im;
    assign io.out3_imag = out_q[3].im;
    assign io.out4_imag = out_q[4].im;
    assign io.out5_imag = out_q[5].im;
    assign io.out6_imag = out_q[6].im;
    assign io.out7_imag = out_q[7].im;
endmodule

// File: tb/tb_fft_wrapper.sv
// tb/tb_fft_wrapper.sv - directed self-checking bench for fft_wrapper
// Expected spectra are hand-derived from the Q1.14 butterfly arithmetic.
module tb_fft_wrapper;
    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    fft_wrapper_if io ();

    fft_wrapper dut (
        .CLK  (clk),
        .RST_N(rst),
        .io   (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int r[8], input int m[8]);
        io.in0_real = 16'(r[0]); io.in0_imag = 16'(m[0]);
        io.in1_real = 16'(r[1]); io.in1_imag = 16'(m[1]);
        io.in2_real = 16'(r[2]); io.in2_imag = 16'(m[2]);
        io.in3_real = 16'(r[3]); io.in3_imag = 16'(m[3]);
        io.in4_real = 16'(r[4]); io.in4_imag = 16'(m[4]);
        io.in5_real = 16'(r[5]); io.in5_imag = 16'(m[5]);
        io.in6_real = 16'(r[6]); io.in6_imag = 16'(m[6]);
        io.in7_real = 16'(r[7]); io.in7_imag = 16'(m[7]);
    endtask

    function automatic int out_re(input int k);
        case (k)
            0: return int'(io.out0_real);
            1: return int'(io.out1_real);
            2: return int'(io.out2_real);
            3: return int'(io.out3_real);
            4: return int'(io.out4_real);
            5: return int'(io.out5_real);
            6: return int'(io.out6_real);
            default: return int'(io.out7_real);
        endcase
    endfunction

    function automatic int out_im(input int k);
        case (k)
            0: return int'(io.out0_imag);
            1: return int'(io.out1_imag);
            2: return int'(io.out2_imag);
            3: return int'(io.out3_imag);
            4: return int'(io.out4_imag);
            5: return int'(io.out5_imag);
            6: return int'(io.out6_imag);
            default: return int'(io.out7_imag);
        endcase
    endfunction

    task automatic check_all(input string tag, input int er[8], input int ei[8]);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s X%0d re", tag, k), out_re(k), er[k]);
            chk($sformatf("%s X%0d im", tag, k), out_im(k), ei[k]);
        end
    endtask

    int zero8 [8];
    int vr    [8];
    int t1_re [8];
    int t1_im [8];
    int t2_re [8];
    int t2_im [8];
    int sat_x0;

    initial begin
        vectors  = 0;
        errors   = 0;
        zero8    = '{0, 0, 0, 0, 0, 0, 0, 0};
        t1_re    = '{200, 50, 0, 50, 0, 50, 0, 50};
        t1_im    = '{0, -121, 0, -21, 0, 21, 0, 121};
        t2_re    = '{2000, -583, 0, -17, 0, -17, 0, -583};
        t2_im    = '{0, -241, 0, -41, 0, 41, 0, 241};
`ifdef FFT_SATURATE_EN
        sat_x0   = 32767;
`else
        sat_x0   = -8;
`endif

        // reset with start held: no transform may follow
        rst      = 1'b1;
        io.write = 1'b0;
        io.start = 1'b1;
        set_in(zero8, zero8);
        tick();
        tick();
        rst      = 1'b0;
        io.start = 1'b0;
        chk("reset ready", int'(io.ready), 0);
        check_all("reset", zero8, zero8);
        tick(); tick(); tick(); tick();
        chk("reset no-run ready", int'(io.ready), 0);

        // step input, write then start, 3-cycle latency
        vr = '{50, 50, 50, 50, 0, 0, 0, 0};
        set_in(vr, zero8);
        io.write = 1'b1;
        tick();
        io.write = 1'b0;
        io.start = 1'b1;
        tick();
        io.start = 1'b0;
        chk("t1 ready after E", int'(io.ready), 0);
        tick(); tick();
        chk("t1 ready at E+2", int'(io.ready), 0);
        tick();
        chk("t1 ready at E+3", int'(io.ready), 1);
        check_all("t1", t1_re, t1_im);

        // back-to-back start with a simultaneous write uses the old buffer
        vr = '{100, 200, 300, 400, 400, 300, 200, 100};
        set_in(vr, zero8);
        io.write = 1'b1;
        io.start = 1'b1;
        tick();
        io.write = 1'b0;
        io.start = 1'b0;
        chk("b2b ready falls", int'(io.ready), 0);
        tick(); tick(); tick();
        chk("b2b ready", int'(io.ready), 1);
        check_all("b2b old buf", t1_re, t1_im);

        io.start = 1'b1;
        tick();
        io.start = 1'b0;
        tick(); tick(); tick();
        chk("t2 ready", int'(io.ready), 1);
        check_all("t2", t2_re, t2_im);

        // start held through S1/S2/S3 must be ignored
        io.start = 1'b1;
        tick();
        tick();
        tick();
        chk("hold ready at E+2", int'(io.ready), 0);
        tick();
        chk("hold ready at E+3", int'(io.ready), 1);
        io.start = 1'b0;
        tick(); tick();
        chk("hold ready stays", int'(io.ready), 1);
        chk("hold X1 re stable", out_re(1), -583);
        chk("hold X7 im stable", out_im(7), 241);

        // reset while in S2 aborts the run
        io.start = 1'b1;
        tick();
        io.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort ready", int'(io.ready), 0);
        chk("abort X0 re", out_re(0), 0);
        chk("abort X7 im", out_im(7), 0);
        tick(); tick(); tick(); tick();
        chk("abort ready never rises", int'(io.ready), 0);

        // full-scale DC exercises wrap/saturate
        vr = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        set_in(vr, zero8);
        io.write = 1'b1;
        tick();
        io.write = 1'b0;
        io.start = 1'b1;
        tick();
        io.start = 1'b0;
        tick(); tick(); tick();
        chk("sat ready", int'(io.ready), 1);
        chk("sat X0 re", out_re(0), sat_x0);
        chk("sat X0 im", out_im(0), 0);
        chk("sat X4 re", out_re(4), 0);
        chk("sat X1 re", out_re(1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
